// File: rtl/dec_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dec_scan_pkg : shared constants, state encoding and row-pick helper for     |
// |                the dec3to8 scan sequencer.              Rev 1.0             |
// +----------------------------------------------------------------------------+
package dec_scan_pkg;

    localparam int SEL_W    = 3;
    localparam int MAX_ROWS = 8;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BLANK  = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;

    typedef struct packed {
        logic [SEL_W-1:0] row;
        logic             wrap;
        logic             none;
    } row_pick_t;

    // Next unmasked row above cur (or from the bottom when from_start);
    // wrap means nothing was found above cur, so row falls back to the lowest.
    function automatic row_pick_t pick_row(
        input logic [SEL_W-1:0]    cur,
        input logic                from_start,
        input logic [MAX_ROWS-1:0] mask,
        input int                  num_rows
    );
        row_pick_t        p;
        logic [SEL_W-1:0] lo_row;
        logic [SEL_W-1:0] hi_row;
        logic             hi_found;
        lo_row   = '0;
        hi_row   = '0;
        hi_found = 1'b0;
        p.none   = 1'b1;
        for (int r = MAX_ROWS - 1; r >= 0; r--) begin
            if ((r < num_rows) && !mask[r]) begin
                p.none = 1'b0;
                lo_row = SEL_W'(r);
                if (from_start || (r > int'(cur))) begin
                    hi_row   = SEL_W'(r);
                    hi_found = 1'b1;
                end
            end
        end
        p.row  = hi_found ? hi_row : lo_row;
        p.wrap = !hi_found;
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dec_scan_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dec_scan_if : control/status bundle of the scan sequencer.                  |
// |               skip_mask exists only when DEC_SCAN_SKIP_EN is defined.      |
// |                                                        Rev 1.0             |
// +----------------------------------------------------------------------------+
interface dec_scan_if
    import dec_scan_pkg::*;
;
    logic             start;
    logic             stop;
    logic             single;
    logic [SEL_W-1:0] sel;
    logic             en;
    logic             row_done;
    logic             sweep_done;
    logic             busy;
`ifdef DEC_SCAN_SKIP_EN
    logic [MAX_ROWS-1:0] skip_mask;

    modport master (output start, stop, single, skip_mask,
                    input  sel, en, row_done, sweep_done, busy);
    modport slave  (input  start, stop, single, skip_mask,
                    output sel, en, row_done, sweep_done, busy);
`else
    modport master (output start, stop, single,
                    input  sel, en, row_done, sweep_done, busy);
    modport slave  (input  start, stop, single,
                    output sel, en, row_done, sweep_done, busy);
`endif
endinterface
`default_nettype wire

// File: rtl/dec_scan_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dec_scan_timer : loadable down-counter that parks at zero.   Rev 1.0       |
// +----------------------------------------------------------------------------+
module dec_scan_timer #(
    parameter int WIDTH = 4
) (
    input  wire              clk,
    input  wire              rst_n,
    input  wire              i_load,
    input  wire  [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_value,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= i_load_val;
        end else if (r_value != '0) begin
            r_value <= r_value - WIDTH'(1);
        end
    end

    assign o_value = r_value;
    assign o_zero  = (r_value == '0);

endmodule
`default_nettype wire

// File: rtl/dec_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dec_scan_ctrl : break-before-make row sweeper driving a dec3to8 decoder.   |
// |                 Optional row skipping with DEC_SCAN_SKIP_EN.  Rev 1.0      |
// +----------------------------------------------------------------------------+
module dec_scan_ctrl
    import dec_scan_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 2,
    parameter int NUM_ROWS     = 8
) (
    input wire        clk,
    input wire        rst_n,
    dec_scan_if.slave bus
);

    localparam int c_TMR_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);
    localparam logic [c_TMR_W-1:0] c_DWELL_LD = c_TMR_W'(DWELL_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_BLANK_LD = c_TMR_W'(BLANK_CYCLES - 1);

    logic [1:0]          r_state;
    logic [SEL_W-1:0]    r_sel;
    logic                r_en;
    logic                r_row_done;
    logic                r_sweep_done;
    logic                r_busy;
    logic                r_stop_pend;
    logic                r_single_q;

    logic [MAX_ROWS-1:0] w_mask;
    logic [SEL_W-1:0]    w_first_row;
    logic                w_first_none;
    logic                w_unused_first_wrap;
    row_pick_t           w_next;
    logic                w_start_ok;
    logic                w_halt;
    logic                w_tmr_load;
    logic [c_TMR_W-1:0]  w_tmr_val;
    logic [c_TMR_W-1:0]  w_unused_tmr_value;
    logic                w_tmr_zero;

`ifdef DEC_SCAN_SKIP_EN
    assign w_mask = bus.skip_mask;
`else
    assign w_mask = '0;
`endif

    assign {w_first_row, w_unused_first_wrap, w_first_none} = pick_row('0, 1'b1, w_mask, NUM_ROWS);
    assign w_next     = pick_row(r_sel, 1'b0, w_mask, NUM_ROWS);
    assign w_start_ok = bus.start && !bus.stop && !w_first_none;
    // A stop landing on the last dwell cycle still counts, so it is OR-ed in directly.
    assign w_halt     = r_stop_pend || bus.stop || (w_next.wrap && r_single_q) || w_next.none;

    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_BLANK_LD;
                end
            end
            S_BLANK: begin
                if (bus.stop) begin
                    w_tmr_load = 1'b1;
                end else if (w_tmr_zero) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_DWELL_LD;
                end
            end
            S_ACTIVE: begin
                if (w_tmr_zero) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = w_halt ? '0 : c_BLANK_LD;
                end
            end
            default: w_tmr_load = 1'b1;
        endcase
    end

    dec_scan_timer #(
        .WIDTH (c_TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_value    (w_unused_tmr_value),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_sel        <= '0;
            r_en         <= 1'b0;
            r_row_done   <= 1'b0;
            r_sweep_done <= 1'b0;
            r_busy       <= 1'b0;
            r_stop_pend  <= 1'b0;
            r_single_q   <= 1'b0;
        end else begin
            r_row_done   <= 1'b0;
            r_sweep_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_state    <= S_BLANK;
                        r_sel      <= w_first_row;
                        r_busy     <= 1'b1;
                        r_single_q <= bus.single;
                    end
                end
                S_BLANK: begin
                    if (bus.stop) begin
                        r_state     <= S_IDLE;
                        r_sel       <= '0;
                        r_busy      <= 1'b0;
                        r_stop_pend <= 1'b0;
                    end else if (w_tmr_zero) begin
                        r_state <= S_ACTIVE;
                        r_en    <= 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (bus.stop) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (w_tmr_zero) begin
                        r_en         <= 1'b0;
                        r_row_done   <= 1'b1;
                        r_sweep_done <= w_next.wrap;
                        if (w_halt) begin
                            r_state     <= S_IDLE;
                            r_sel       <= '0;
                            r_busy      <= 1'b0;
                            r_stop_pend <= 1'b0;
                        end else begin
                            r_state <= S_BLANK;
                            r_sel   <= w_next.row;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.sel        = r_sel;
    assign bus.en         = r_en;
    assign bus.row_done   = r_row_done;
    assign bus.sweep_done = r_sweep_done;
    assign bus.busy       = r_busy;

endmodule
`default_nettype wire
